// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions for the CLA adder/subtractor family.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package cla_pkg;

    // Every lookahead group in this family is one nibble wide.
    localparam int GRP_W = 4;

    // Per-bit generate/propagate pair of one lookahead group.
    typedef struct packed {
        logic [GRP_W-1:0] g;
        logic [GRP_W-1:0] p;
    } gp_t;

    // Number of lookahead groups (and so pipeline stages) for an operand width.
    function automatic int nstg(input int width);
        return width / GRP_W;
    endfunction

endpackage

// File: rtl/cla_sub_group.sv
// 4-bit carry-lookahead slice: s = a + nb + c_in, with group generate/propagate.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
//
// Ports:
//   a, nb  : group operands (nb is the already-inverted subtrahend nibble)
//   c_in   : carry into the group (carry = ~borrow in subtract use)
//   s      : nibble sum (difference nibble in subtract use)
//   c_out  : carry out of the group
//   G, P   : group generate / propagate for a higher lookahead level
module cla_sub_group
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] nb,
    input  logic             c_in,
    output logic [GRP_W-1:0] s,
    output logic             c_out,
    output logic             G,
    output logic             P
);

    gp_t        gp;
    logic [3:0] c;

    always_comb begin
        gp.g = a & nb;
        gp.p = a ^ nb;

        // Every internal carry is a flat sum of products of g/p and c_in,
        // so no carry depends on another carry inside the group.
        c[0] = c_in;
        c[1] = gp.g[0] | (gp.p[0] & c_in);
        c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & c_in);
        c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
             | (gp.p[2] & gp.p[1] & gp.p[0] & c_in);

        G = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
          | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0]);
        P = &gp.p;

        c_out = G | (P & c_in);
        s     = gp.p ^ c;
    end

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined CLA subtractor: diff = a - b - b_in, one nibble lookahead group per stage.
// Latency: WIDTH/4 register stages from acceptance to out_valid (1 beat/cycle throughput).
// Backpressure: valid/ready; empty stages always accept, a full pipe stalls in_ready
//               only while out_ready is low, and the output is held during the stall.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake for a, b, b_in
//   out_valid / out_ready : result handshake for diff, b_out, ovf
//   diff                  : a - b - b_in modulo 2^WIDTH
//   b_out                 : borrow out (unsigned a < b + b_in)
//   ovf                   : signed two's-complement overflow
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NSTG = nstg(WIDTH);
    localparam int MSB  = WIDTH - 1;

    // Stage registers. Operands ride along unchanged so each stage can pick
    // its own nibble; d_q holds finished difference nibbles 0..k at stage k.
    // bw_q stores the group borrow (inverted carry) so that a reset pipe
    // presents b_out = 0 without extra gating.
    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  bw_q;
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] d_q [NSTG];

    // What each stage would load: the previous stage, or the inputs for stage 0.
    logic [NSTG-1:0]  src_v;
    logic [WIDTH-1:0] src_a [NSTG];
    logic [WIDTH-1:0] src_b [NSTG];
    logic [WIDTH-1:0] src_d [NSTG];
    logic [WIDTH-1:0] nxt_d [NSTG];

    logic [NSTG-1:0]  c_in;
    logic [NSTG-1:0]  co;
    logic [NSTG-1:0]  grp_c;
    logic [NSTG-1:0]  grp_g;
    logic [NSTG-1:0]  grp_p;
    logic [GRP_W-1:0] sum [NSTG];

    // adv[k]: stage k may load this cycle. A stage is free when empty or
    // when everything downstream of it moves, so bubbles are squeezed out.
    logic [NSTG:0]    adv;

    assign adv[NSTG] = out_ready;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_a[k] = a;
            assign src_b[k] = b;
            assign src_d[k] = '0;
            // Subtract runs as a + ~b + ~b_in.
            assign c_in[k]  = ~b_in;
        end else begin : g_body
            assign src_v[k] = vld_q[k-1];
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_d[k] = d_q[k-1];
            assign c_in[k]  = ~bw_q[k-1];
        end

        cla_sub_group u_grp (
            .a     (src_a[k][GRP_W*k +: GRP_W]),
            .nb    (~src_b[k][GRP_W*k +: GRP_W]),
            .c_in  (c_in[k]),
            .s     (sum[k]),
            .c_out (grp_c[k]),
            .G     (grp_g[k]),
            .P     (grp_p[k])
        );

        // grp_c already equals G | P & c_in; the explicit terms keep the
        // group lookahead visible here and collapse to the same gate.
        assign co[k]  = grp_c[k] | grp_g[k] | (grp_p[k] & c_in[k]);

        assign adv[k] = ~vld_q[k] | adv[k+1];
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            nxt_d[k] = src_d[k];
            nxt_d[k][GRP_W*k +: GRP_W] = sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            bw_q  <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= src_v[k];
                    bw_q[k]  <= ~co[k];
                    a_q[k]   <= src_a[k];
                    b_q[k]   <= src_b[k];
                    d_q[k]   <= nxt_d[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[NSTG-1];
    assign diff      = d_q[NSTG-1];
    assign b_out     = bw_q[NSTG-1];
    // Overflow only possible when operand signs differ; then the result
    // must keep the minuend's sign.
    assign ovf       = (a_q[NSTG-1][MSB] != b_q[NSTG-1][MSB])
                    && (d_q[NSTG-1][MSB] != a_q[NSTG-1][MSB]);

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe (WIDTH=16): directed cases, backpressure,
// mid-flight reset and a random soak against an arithmetic reference model.
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;

    always #5 clk = ~clk;

    cla_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc_n  = 0;
    int          last_lat = 0;
    bit          acc_f;
    bit          emit_f;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_res;
    logic [17:0] exp_q [$];
    int          acc_cyc_q [$];
    logic [17:0] em_log [$];
    int          em_cyc [$];

    // Reference: {b_out, ovf, diff} straight from unsigned arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
        logic [16:0] full;
        logic [15:0] d;
        full = {1'b0, x} - {1'b0, y} - {16'b0, bi};
        d    = full[15:0];
        return {full[16], (x[15] != y[15]) && (d[15] != x[15]), d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: drive at negedge, sample handshakes 1 time unit later.
    task automatic cyc(input bit v, input logic [15:0] aa, input logic [15:0] bb,
                       input bit bi, input bit ordy);
        logic [17:0] e;
        int          t;
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        b_in      = bi;
        out_ready = ordy;
        #1;
        cyc_n++;
        if (prev_stall)
            check("hold", 32'({b_out, ovf, diff}), 32'(prev_res));
        acc_f  = in_valid && in_ready;
        emit_f = out_valid && out_ready;
        if (emit_f) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = acc_cyc_q.pop_front();
                last_lat = cyc_n - t;
                check("result", 32'({b_out, ovf, diff}), 32'(e));
            end
            em_log.push_back({b_out, ovf, diff});
            em_cyc.push_back(cyc_n);
        end
        if (acc_f) begin
            exp_q.push_back(model(aa, bb, bi));
            acc_cyc_q.push_back(cyc_n);
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = {b_out, ovf, diff};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_q.delete();
        acc_cyc_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    endtask

    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic        bp_i [6];
    int          n_acc;
    int          guard;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_b_out",     32'(b_out),     32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Basic subtract and latency
        em_log.delete(); em_cyc.delete();
        cyc(1'b1, 16'h1234, 16'h0234, 1'b0, 1'b1);
        idle(6);
        check("basic_count", 32'(em_log.size()), 32'd1);
        check("basic_val",   32'(em_log[0]), 32'({1'b0, 1'b0, 16'h1000}));
        check("basic_lat",   32'(last_lat), 32'd4);

        // Underflow pair
        em_log.delete(); em_cyc.delete();
        cyc(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 16'h5555, 16'h5555, 1'b1, 1'b1);
        idle(6);
        check("uflow_count", 32'(em_log.size()), 32'd2);
        check("uflow_0",     32'(em_log[0]), 32'({1'b1, 1'b0, 16'hFFFF}));
        check("uflow_1",     32'(em_log[1]), 32'({1'b1, 1'b0, 16'hFFFF}));
        check("uflow_tput",  32'(em_cyc[1] - em_cyc[0]), 32'd1);

        // Signed overflow pair
        em_log.delete(); em_cyc.delete();
        cyc(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        idle(6);
        check("ovf_count", 32'(em_log.size()), 32'd2);
        check("ovf_0",     32'(em_log[0]), 32'({1'b0, 1'b1, 16'h7FFF}));
        check("ovf_1",     32'(em_log[1]), 32'({1'b1, 1'b1, 16'h8000}));

        // Backpressure: 6 beats offered into a stalled pipe
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_i[i] = 1'($urandom_range(0, 1));
        end
        em_log.delete(); em_cyc.delete();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, bp_a[n_acc], bp_b[n_acc], bp_i[n_acc], 1'b0);
            if (acc_f) n_acc++;
        end
        check("bp_accepted",  32'(n_acc), 32'd4);
        check("bp_in_ready",  32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        guard = 0;
        while (em_log.size() < 6 && guard < 30) begin
            if (n_acc < 6) begin
                cyc(1'b1, bp_a[n_acc], bp_b[n_acc], bp_i[n_acc], 1'b1);
                if (acc_f) n_acc++;
            end else begin
                cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            end
            guard++;
        end
        check("bp_emitted", 32'(em_log.size()), 32'd6);
        check("bp_tput",    32'(em_cyc[5] - em_cyc[0]), 32'd5);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        do_reset();
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_diff",      32'(diff),      32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        em_log.delete(); em_cyc.delete();
        idle(8);
        check("mrst_no_stale", 32'(em_log.size()), 32'd0);

        // Random soak
        n_acc = 0;
        guard = 0;
        while (n_acc < 10000 && guard < 60000) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if (acc_f) n_acc++;
            guard++;
        end
        check("soak_accepted", 32'(n_acc), 32'd10000);
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            guard++;
        end
        check("soak_lost", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
